// File: rtl/time_pkg.sv
// Shared types, constants and field-wrap helpers for the time-entry block.
package time_pkg;

    localparam int FIELD_W     = 6;
    localparam int ACC_W       = 2 * FIELD_W;
    localparam int CNT_W       = 3;
    localparam int SEC_PER_MIN = 60;
    localparam int MAX_SEC     = 59;

    typedef enum logic [1:0] {EDIT, CONV, DONE} te_state_t;

    function automatic logic [FIELD_W-1:0] wrap_inc(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] top
    );
        return (v == top) ? '0 : v + FIELD_W'(1);
    endfunction

    function automatic logic [FIELD_W-1:0] wrap_dec(
        input logic [FIELD_W-1:0] v,
        input logic [FIELD_W-1:0] top
    );
        return (v == '0) ? top : v - FIELD_W'(1);
    endfunction

endpackage

// File: rtl/min_to_sec_conv.sv
// Serial shift-add: acc = sec + 60*mreg, one minute bit per cycle.
module min_to_sec_conv
    import time_pkg::*;
(
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic [FIELD_W-1:0] mreg,
    input  logic [FIELD_W-1:0] sec,
    output logic [ACC_W-1:0]   acc,
    output logic               done
);

    localparam logic [ACC_W-1:0] SPM  = ACC_W'(SEC_PER_MIN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FIELD_W - 1);

    logic [FIELD_W-1:0] mreg_q, mreg_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               run_q, run_d;

    always_comb begin
        mreg_d = mreg_q;
        acc_d  = acc_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        if (start) begin
            mreg_d = mreg;
            acc_d  = {{(ACC_W-FIELD_W){1'b0}}, sec};
            cnt_d  = '0;
            run_d  = 1'b1;
        end else if (run_q) begin
            if (mreg_q[cnt_q]) acc_d = acc_q + (SPM << cnt_q);
            if (cnt_q == LAST) begin
                cnt_d = '0;
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            mreg_q <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
        end else begin
            mreg_q <= mreg_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
        end
    end

    assign acc  = acc_q;
    assign done = run_q && (cnt_q == LAST);

endmodule

// File: rtl/time_entry.sv
// Minutes:seconds editor with serial conversion to total seconds.
// Define TIME_ENTRY_CARRY_EN to carry seconds wrap into minutes.
module time_entry
    import time_pkg::*;
#(
    parameter int MAX_MIN = 59
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               en,
    input  logic               field_tgl,
    input  logic               inc,
    input  logic               dec,
    input  logic               clear,
    input  logic               confirm,
    output logic [ACC_W-1:0]   disp_time,
    output logic               field,
    output logic               busy,
    output logic [ACC_W-1:0]   set_time,
    output logic               set_valid
);

    localparam logic [FIELD_W-1:0] MIN_TOP = FIELD_W'(MAX_MIN);
    localparam logic [FIELD_W-1:0] SEC_TOP = FIELD_W'(MAX_SEC);

    te_state_t          state_q, state_d;
    logic [FIELD_W-1:0] min_q, min_d;
    logic [FIELD_W-1:0] sec_q, sec_d;
    logic               field_q, field_d;
    logic               busy_q, busy_d;
    logic [ACC_W-1:0]   set_time_q, set_time_d;
    logic               set_valid_q, set_valid_d;

    logic               conv_start;
    logic [ACC_W-1:0]   conv_acc;
    logic               conv_done;

    min_to_sec_conv u_conv (
        .clk   (clk),
        .nrst  (nrst),
        .start (conv_start),
        .mreg  (min_q),
        .sec   (sec_q),
        .acc   (conv_acc),
        .done  (conv_done)
    );

    always_comb begin
        state_d     = state_q;
        min_d       = min_q;
        sec_d       = sec_q;
        field_d     = field_q;
        busy_d      = busy_q;
        set_time_d  = set_time_q;
        set_valid_d = 1'b0;
        conv_start  = 1'b0;
        unique case (state_q)
            EDIT: begin
                if (clear) begin
                    min_d = '0;
                    sec_d = '0;
                end else if (confirm) begin
                    conv_start = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = CONV;
                end else if (en && field_tgl) begin
                    field_d = ~field_q;
                end else if (en && (inc ^ dec)) begin
                    if (field_q) begin
                        min_d = inc ? wrap_inc(min_q, MIN_TOP)
                                    : wrap_dec(min_q, MIN_TOP);
                    end else begin
                        sec_d = inc ? wrap_inc(sec_q, SEC_TOP)
                                    : wrap_dec(sec_q, SEC_TOP);
`ifdef TIME_ENTRY_CARRY_EN
                        if (inc && sec_q == SEC_TOP)
                            min_d = wrap_inc(min_q, MIN_TOP);
                        if (dec && sec_q == '0)
                            min_d = wrap_dec(min_q, MIN_TOP);
`endif
                    end
                end
            end
            CONV: begin
                if (conv_done) state_d = DONE;
            end
            DONE: begin
                set_valid_d = 1'b1;
                set_time_d  = conv_acc;
                busy_d      = 1'b0;
                state_d     = EDIT;
            end
            default: state_d = EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= EDIT;
            min_q       <= '0;
            sec_q       <= '0;
            field_q     <= 1'b0;
            busy_q      <= 1'b0;
            set_time_q  <= '0;
            set_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            field_q     <= field_d;
            busy_q      <= busy_d;
            set_time_q  <= set_time_d;
            set_valid_q <= set_valid_d;
        end
    end

    assign disp_time = {min_q, sec_q};
    assign field     = field_q;
    assign busy      = busy_q;
    assign set_time  = set_time_q;
    assign set_valid = set_valid_q;

endmodule

// File: tb/tb_time_entry.sv
// Scoreboard bench for time_entry: edits, conversions, busy lockout, reset abort.
module tb_time_entry;

    localparam int MAXM = 59;

    logic        clk = 1'b0;
    logic        nrst, en, field_tgl, inc, dec, clear, confirm;
    logic [11:0] disp_time, set_time;
    logic        field, busy, set_valid;

    int n_chk = 0;
    int n_err = 0;
    int sv_seen = 0;
    int q[$];
    int mm = 0;
    int ss = 0;
    bit fld = 1'b0;

    time_entry #(.MAX_MIN(MAXM)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .en        (en),
        .field_tgl (field_tgl),
        .inc       (inc),
        .dec       (dec),
        .clear     (clear),
        .confirm   (confirm),
        .disp_time (disp_time),
        .field     (field),
        .busy      (busy),
        .set_time  (set_time),
        .set_valid (set_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (nrst && set_valid) sv_seen++;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input bit t, i, d, c, cf);
        field_tgl = t; inc = i; dec = d; clear = c; confirm = cf;
        @(negedge clk);
        field_tgl = 0; inc = 0; dec = 0; clear = 0; confirm = 0;
    endtask

    task automatic edit(input bit t, i, d, c);
        drive(t, i, d, c, 1'b0);
        if (c) begin
            mm = 0; ss = 0;
        end else if (en) begin
            if (t) fld = !fld;
            else if (i != d) begin
                if (fld) mm = i ? (mm == MAXM ? 0 : mm + 1)
                                : (mm == 0 ? MAXM : mm - 1);
                else begin
`ifdef TIME_ENTRY_CARRY_EN
                    if (i && ss == 59) mm = (mm == MAXM) ? 0 : mm + 1;
                    if (d && ss == 0)  mm = (mm == 0) ? MAXM : mm - 1;
`endif
                    ss = i ? (ss == 59 ? 0 : ss + 1) : (ss == 0 ? 59 : ss - 1);
                end
            end
        end
        check("disp_time", disp_time, {20'd0, mm[5:0], ss[5:0]});
        check("field", field, fld);
    endtask

    task automatic reps(input int n, input bit t, i, d);
        for (int k = 0; k < n; k++) edit(t, i, d, 1'b0);
    endtask

    task automatic run_conv(input int expv, input bit junk);
        logic [11:0] held;
        int n;
        int e;
        held = disp_time;
        q.push_back(expv);
        drive(0, 0, 0, 0, 1);
        n = 0;
        while (!set_valid && n < 20) begin
            check("busy", busy, 1);
            check("frozen", disp_time, held);
            if (junk) begin
                en        = 1'($urandom_range(0, 1));
                field_tgl = 1'($urandom_range(0, 1));
                inc       = 1'($urandom_range(0, 1));
                dec       = 1'($urandom_range(0, 1));
                clear     = 1'($urandom_range(0, 1));
                confirm   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            n++;
            en = 1; field_tgl = 0; inc = 0; dec = 0; clear = 0; confirm = 0;
        end
        e = q.pop_front();
        check("set_valid_seen", set_valid, 1);
        if (set_valid) begin
            check("latency", n, 7);
            check("set_time", set_time, e);
            check("busy_done", busy, 0);
            check("disp_after", disp_time, held);
        end
        @(negedge clk);
        check("valid_pulse", set_valid, 0);
        check("set_time_hold", set_time, expv);
    endtask

    initial begin
        nrst = 0; en = 1;
        field_tgl = 0; inc = 0; dec = 0; clear = 0; confirm = 0;
        repeat (3) @(negedge clk);
        nrst = 1;
        check("rst_disp", disp_time, 0);
        check("rst_field", field, 0);
        check("rst_set_time", set_time, 0);
        check("rst_busy", busy, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("idle_valid", set_valid, 0);
        end

        reps(59, 0, 1, 0);
        check("sec59", disp_time, 12'd59);
        edit(0, 1, 0, 0);
`ifdef TIME_ENTRY_CARRY_EN
        check("sec_carry", disp_time, {6'd1, 6'd0});
`else
        check("sec_wrap", disp_time, 12'd0);
`endif
        edit(0, 0, 0, 1);
        edit(0, 0, 1, 0);
        edit(0, 0, 0, 1);

        edit(1, 0, 0, 0);
        edit(0, 0, 1, 0);
        check("min59", disp_time, {6'd59, 6'd0});
        reps(4, 0, 1, 0);
        check("min3", disp_time, {6'd3, 6'd0});
        edit(0, 1, 1, 0);
        check("incdec", disp_time, {6'd3, 6'd0});
        en = 0;
        edit(0, 1, 0, 0);
        edit(1, 0, 0, 0);
        check("en_off", disp_time, {6'd3, 6'd0});
        en = 1;

        edit(0, 0, 0, 1);
        reps(12, 0, 1, 0);
        edit(1, 0, 0, 0);
        reps(34, 0, 1, 0);
        check("set1234", disp_time, {6'd12, 6'd34});
        run_conv(754, 0);

        edit(0, 0, 0, 1);
        reps(59, 0, 1, 0);
        edit(1, 0, 0, 0);
        edit(0, 0, 1, 0);
        check("set5959", disp_time, {6'd59, 6'd59});
        run_conv(3599, 0);

        edit(0, 0, 0, 1);
        run_conv(0, 0);

        reps(5, 0, 1, 0);
        edit(1, 0, 0, 0);
        reps(7, 0, 1, 0);
        check("set0507", disp_time, {6'd5, 6'd7});
        run_conv(307, 1);

        edit(0, 1, 0, 0);
        check("edit_after", set_time, 307);

        drive(0, 0, 0, 1, 1);
        mm = 0; ss = 0;
        check("clr_cf_disp", disp_time, 0);
        for (int k = 0; k < 8; k++) begin
            check("clr_cf_busy", busy, 0);
            check("clr_cf_valid", set_valid, 0);
            @(negedge clk);
        end

        reps(3, 0, 1, 0);
        drive(0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        check("abort_busy", busy, 1);
        nrst = 0;
        @(negedge clk);
        nrst = 1;
        mm = 0; ss = 0; fld = 0;
        check("abort_disp", disp_time, 0);
        check("abort_field", field, 0);
        check("abort_set_time", set_time, 0);
        check("abort_busy_low", busy, 0);
        for (int k = 0; k < 10; k++) begin
            check("abort_valid", set_valid, 0);
            @(negedge clk);
        end
        edit(0, 1, 0, 0);
        check("abort_edit", disp_time, 12'd1);

        check("valid_count", sv_seen, 4);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
